// File: rtl/capture_pkg.sv
// Shared types and record helpers for the capture readback path.
// READBACK_SIGN_EXT_EN selects sign extension of 14-bit ADC codes.
package capture_pkg;

    localparam int ADC_W       = 14;
    localparam int ADDR_STRIDE = 4;
    localparam int CNT_W       = 25;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic        fend;
        logic        last;
        logic [31:0] word;
    } fifo_ent_t;

    function automatic logic [31:0] pack_record(
        input logic [ADC_W-1:0] a,
        input logic [ADC_W-1:0] b
    );
        return {2'b00, b, 2'b00, a};
    endfunction

    function automatic logic [ADC_W-1:0] rec_a(input logic [31:0] w);
        return w[ADC_W-1:0];
    endfunction

    function automatic logic [ADC_W-1:0] rec_b(input logic [31:0] w);
        return w[16+ADC_W-1:16];
    endfunction

    function automatic logic [15:0] ext_sample(input logic [ADC_W-1:0] x);
`ifdef READBACK_SIGN_EXT_EN
        return {{(16-ADC_W){x[ADC_W-1]}}, x};
`else
        return {{(16-ADC_W){1'b0}}, x};
`endif
    endfunction

endpackage

// File: rtl/readback_skid_fifo.sv
// First-word-fall-through synchronous FIFO absorbing stream backpressure.
// DEPTH must be a power of two so the pointers wrap naturally.
module readback_skid_fifo #(
    parameter  int W     = 34,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/capture_readback.sv
// Streams ADC capture records from sample memory with credit-based reads.
// READBACK_SIGN_EXT_EN selects sign extension of the 14-bit samples.
module capture_readback
    import capture_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [CNT_W-1:0] num_reps,
    output logic             mem_rd_en,
    output logic [31:0]      mem_rd_addr,
    input  logic [31:0]      mem_rd_data,
    output logic [15:0]      m_data_A,
    output logic [15:0]      m_data_B,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             m_frame_end,
    output logic             busy,
    output logic             done
);

    localparam int FW = $bits(fifo_ent_t);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] ns_q, ns_d;
    logic [CNT_W-1:0] smp_q, smp_d;
    logic [CNT_W-1:0] rep_q, rep_d;

    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] last_q;
    logic [RD_LATENCY-1:0] fend_q;

    logic      issue;
    logic      tag_last;
    logic      tag_fend;
    logic      credit_ok;
    int        inflight;
    logic      pop;
    logic      fifo_full;
    logic      fifo_empty;
    logic [CW-1:0] fifo_cnt;
    fifo_ent_t in_ent;
    fifo_ent_t head;
    logic      unused_ok;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight += int'(vld_q[i]);
        end
    end

    assign credit_ok = (inflight + int'(fifo_cnt)) < FIFO_DEPTH;
    assign tag_last  = (smp_q == '0);
    assign tag_fend  = (smp_q == '0) && (rep_q == '0);
    assign pop       = m_valid && m_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ns_d    = ns_q;
        smp_d   = smp_q;
        rep_d   = rep_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ns_d    = num_samples;
                    smp_d   = num_samples;
                    rep_d   = num_reps;
                    addr_d  = base_addr;
                    state_d = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 32'(ADDR_STRIDE);
                    if (smp_q == '0) begin
                        smp_d = ns_q;
                        rep_d = rep_q - 1'b1;
                        if (rep_q == '0) state_d = DRAIN;
                    end else begin
                        smp_d = smp_q - 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // leave as the last beat pops so done lands on the next cycle
                if (inflight == 0 &&
                    (fifo_empty || (fifo_cnt == CW'(1) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ns_q    <= '0;
            smp_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ns_q    <= ns_d;
            smp_q   <= smp_d;
            rep_q   <= rep_d;
        end
    end

    // tags ride alongside the memory latency; clearing drops late data
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
            fend_q <= '0;
        end else begin
            vld_q[0]  <= issue;
            last_q[0] <= issue && tag_last;
            fend_q[0] <= issue && tag_fend;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                fend_q[i] <= fend_q[i-1];
            end
        end
    end

    always_comb begin
        in_ent      = '0;
        in_ent.fend = fend_q[RD_LATENCY-1];
        in_ent.last = last_q[RD_LATENCY-1];
        in_ent.word = mem_rd_data;
    end

    readback_skid_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_q[RD_LATENCY-1]),
        .push_data (in_ent),
        .pop       (pop),
        .head      (head),
        .count     (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr_q;
    assign m_valid     = !fifo_empty;

    always_comb begin
        m_data_A    = '0;
        m_data_B    = '0;
        m_last      = 1'b0;
        m_frame_end = 1'b0;
        if (m_valid) begin
            m_data_A    = ext_sample(rec_a(head.word));
            m_data_B    = ext_sample(rec_b(head.word));
            m_last      = head.last;
            m_frame_end = head.fend;
        end
    end

    assign unused_ok = ^{head.word[31:30], head.word[15:14], fifo_full};

endmodule

// File: tb/tb_capture_readback.sv
// Directed bench for capture_readback with a fixed-latency memory model.
// Expectations follow READBACK_SIGN_EXT_EN when it is defined.
module tb_capture_readback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [24:0] num_samples;
    logic [24:0] num_reps;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [15:0] m_data_A;
    logic [15:0] m_data_B;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        m_frame_end;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    capture_readback #(
        .RD_LATENCY (2),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_samples (num_samples),
        .num_reps    (num_reps),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_data_A    (m_data_A),
        .m_data_B    (m_data_B),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .m_frame_end (m_frame_end),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_4000) return 32'h1FFF_2001;
        return {2'b00, ~a[15:2], 2'b00, a[15:2]};
    endfunction

    function automatic logic [15:0] ext14(input logic [13:0] x);
`ifdef READBACK_SIGN_EXT_EN
        return {{2{x[13]}}, x};
`else
        return {2'b00, x};
`endif
    endfunction

    function automatic logic [33:0] exp_beat(input logic [31:0] a,
                                             input logic lst,
                                             input logic fe);
        logic [13:0] sa;
        sa = a[15:2];
        return {fe, lst, ext14(~sa), ext14(sa)};
    endfunction

    // two-cycle read latency memory
    logic [31:0] ap0, ap1;
    always @(posedge clk) begin
        ap0 <= mem_rd_addr;
        ap1 <= ap0;
    end
    assign mem_rd_data = mem_word(ap1);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          issued_n, popped_n, valid_seen, done_n;
    int          start_cyc, first_valid_cyc, last_pop_cyc, done_cyc;
    int          credit_viol, hold_viol, max_out;
    bit          st_seen, fv_seen, hold_pend;
    logic [33:0] hold_val;
    logic [33:0] beats[$];
    logic [31:0] addrs[$];

    always @(negedge clk) begin
        int          outst;
        logic [33:0] cur;
        cur = {m_frame_end, m_last, m_data_B, m_data_A};
        if (rst) begin
            issued_n = 0; popped_n = 0; valid_seen = 0; done_n = 0;
            start_cyc = 0; first_valid_cyc = 0;
            last_pop_cyc = 0; done_cyc = 0;
            credit_viol = 0; hold_viol = 0; max_out = 0;
            st_seen = 0; fv_seen = 0; hold_pend = 0;
            beats.delete();
            addrs.delete();
        end else begin
            outst = issued_n - popped_n;
            if (outst > max_out) max_out = outst;
            if (mem_rd_en) begin
                if (outst >= 8) credit_viol++;
                issued_n++;
                addrs.push_back(mem_rd_addr);
            end
            if (start && !st_seen) begin
                st_seen = 1; start_cyc = cyc;
            end
            if (m_valid) begin
                valid_seen++;
                if (!fv_seen) begin
                    fv_seen = 1; first_valid_cyc = cyc;
                end
            end
            if (hold_pend && cur !== hold_val) hold_viol++;
            hold_pend = m_valid && !m_ready;
            hold_val  = cur;
            if (m_valid && m_ready) begin
                beats.push_back(cur);
                popped_n++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic launch(input logic [31:0] b, input logic [24:0] s,
                          input logic [24:0] r);
        @(posedge clk); #1;
        base_addr = b; num_samples = s; num_reps = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b1;
        base_addr = '0; num_samples = '0; num_reps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({mem_rd_en, mem_rd_addr, m_valid, m_last, m_frame_end,
             m_data_A, m_data_B, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b addr=%h v=%b A=%h B=%h busy=%b done=%b want all 0",
                     mem_rd_en, mem_rd_addr, m_valid, m_data_A, m_data_B, busy, done);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        m_ready = 1'b1;
        launch(32'h100, 25'd3, 25'd0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL basic_busy got %b want 1", busy);
        end
        wait_done(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout got no done want done"); end
        total++;
        if (addrs.size() !== 4) begin
            bad++; $display("FAIL basic_nreads got %0d want 4", addrs.size());
        end
        for (int i = 0; i < 4 && i < addrs.size(); i++) begin
            total++;
            if (addrs[i] !== 32'h100 + 32'(4*i)) begin
                bad++; $display("FAIL basic_addr[%0d] got %h want %h",
                                i, addrs[i], 32'h100 + 32'(4*i));
            end
        end
        total++;
        if (beats.size() !== 4) begin
            bad++; $display("FAIL basic_nbeats got %0d want 4", beats.size());
        end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            logic [33:0] e;
            e = exp_beat(32'h100 + 32'(4*i), i == 3, i == 3);
            total++;
            if (beats[i] !== e) begin
                bad++; $display("FAIL basic_beat[%0d] got %h want %h", i, beats[i], e);
            end
        end
        total++;
        if (first_valid_cyc - start_cyc !== 4) begin
            bad++; $display("FAIL basic_latency got %0d want 4",
                            first_valid_cyc - start_cyc);
        end
        total++;
        if (done_cyc - last_pop_cyc !== 1) begin
            bad++; $display("FAIL basic_done_timing got %0d want 1",
                            done_cyc - last_pop_cyc);
        end
        total++;
        if (done_n !== 1 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse got n=%0d busy=%b want n=1 busy=0",
                            done_n, busy);
        end
    endtask

    task automatic test_reps();
        bit ok;
        do_reset();
        m_ready = 1'b1;
        launch(32'h200, 25'd1, 25'd2);
        wait_done(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL reps_timeout got no done want done"); end
        total++;
        if (beats.size() !== 6) begin
            bad++; $display("FAIL reps_nbeats got %0d want 6", beats.size());
        end
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            logic [33:0] e;
            e = exp_beat(32'h200 + 32'(4*i), (i % 2) == 1, i == 5);
            total++;
            if (beats[i] !== e) begin
                bad++; $display("FAIL reps_beat[%0d] got %h want %h", i, beats[i], e);
            end
        end
    endtask

    task automatic test_backpressure();
        int  stall;
        bit  ok;
        do_reset();
        m_ready = 1'b0;
        stall = 20;
        launch(32'h1000, 25'd15, 25'd1);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done_n > 0) begin ok = 1; break; end
            if (stall > 0) begin
                m_ready = 1'b0; stall--;
            end else begin
                m_ready = ~m_ready;
                if ($urandom_range(0, 3) == 0) stall = $urandom_range(1, 20);
            end
        end
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout got no done want done"); end
        total++;
        if (beats.size() !== 32) begin
            bad++; $display("FAIL bp_nbeats got %0d want 32", beats.size());
        end
        for (int i = 0; i < 32 && i < beats.size(); i++) begin
            logic [33:0] e;
            e = exp_beat(32'h1000 + 32'(4*i), (i % 16) == 15, i == 31);
            total++;
            if (beats[i] !== e) begin
                bad++; $display("FAIL bp_beat[%0d] got %h want %h", i, beats[i], e);
            end
        end
        total++;
        if (credit_viol !== 0) begin
            bad++; $display("FAIL bp_credit got %0d violations want 0", credit_viol);
        end
        total++;
        if (max_out !== 8) begin
            bad++; $display("FAIL bp_max_outstanding got %0d want 8", max_out);
        end
        total++;
        if (hold_viol !== 0) begin
            bad++; $display("FAIL bp_hold got %0d changes want 0", hold_viol);
        end
    endtask

    task automatic test_wrap();
        bit          ok;
        logic [31:0] ea [4];
        ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC;
        ea[2] = 32'h0000_0000; ea[3] = 32'h0000_0004;
        do_reset();
        m_ready = 1'b1;
        launch(32'hFFFF_FFF8, 25'd3, 25'd0);
        wait_done(100, ok);
        total++;
        if (!ok || addrs.size() !== 4) begin
            bad++; $display("FAIL wrap_reads got ok=%0d n=%0d want ok=1 n=4",
                            ok, addrs.size());
        end
        for (int i = 0; i < 4 && i < addrs.size(); i++) begin
            total++;
            if (addrs[i] !== ea[i]) begin
                bad++; $display("FAIL wrap_addr[%0d] got %h want %h", i, addrs[i], ea[i]);
            end
        end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            logic [33:0] e;
            e = exp_beat(ea[i], i == 3, i == 3);
            total++;
            if (beats[i] !== e) begin
                bad++; $display("FAIL wrap_beat[%0d] got %h want %h", i, beats[i], e);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_reset();
        m_ready = 1'b1;
        launch(32'h500, 25'd7, 25'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_rd_en, mem_rd_addr, m_valid, m_last, m_frame_end,
             m_data_A, m_data_B, busy, done} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got en=%b addr=%h v=%b busy=%b done=%b want all 0",
                     mem_rd_en, mem_rd_addr, m_valid, busy, done);
        end
        repeat (10) @(negedge clk);
        total++;
        if (valid_seen !== 0 || issued_n !== 0) begin
            bad++; $display("FAIL midrst_quiet got valid=%0d reads=%0d want 0 0",
                            valid_seen, issued_n);
        end
        launch(32'h300, 25'd2, 25'd0);
        wait_done(100, ok);
        total++;
        if (!ok || beats.size() !== 3) begin
            bad++; $display("FAIL midrst_rerun got ok=%0d n=%0d want ok=1 n=3",
                            ok, beats.size());
        end
        for (int i = 0; i < 3 && i < beats.size(); i++) begin
            logic [33:0] e;
            e = exp_beat(32'h300 + 32'(4*i), i == 2, i == 2);
            total++;
            if (beats[i] !== e) begin
                bad++; $display("FAIL midrst_beat[%0d] got %h want %h", i, beats[i], e);
            end
        end
    endtask

    task automatic test_format();
        bit          ok;
        logic [33:0] e;
`ifdef READBACK_SIGN_EXT_EN
        e = {1'b1, 1'b1, 16'h1FFF, 16'hE001};
`else
        e = {1'b1, 1'b1, 16'h1FFF, 16'h2001};
`endif
        do_reset();
        m_ready = 1'b1;
        launch(32'h4000, 25'd0, 25'd0);
        wait_done(100, ok);
        total++;
        if (!ok || beats.size() !== 1) begin
            bad++; $display("FAIL fmt_count got ok=%0d n=%0d want ok=1 n=1",
                            ok, beats.size());
        end
        if (beats.size() > 0) begin
            total++;
            if (beats[0] !== e) begin
                bad++; $display("FAIL fmt_beat got %h want %h", beats[0], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reps();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_format();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
